// File: rtl/seq_div_nbits.sv
// seq_div_nbits -- sequential unsigned restoring divider.
//
// One quotient bit is resolved per clock edge, so a division takes exactly
// `width` cycles from the accepting edge to the done pulse, whatever the
// operand values. The per-step trial subtraction goes through full_sub_nbits,
// which keeps the divide path on the same subtractor structure as the rest of
// the calculator datapath.
//
// Ports
//   clk_i    in            clock, rising edge
//   rst_ni   in            asynchronous active-low reset
//   start_i  in            request a division (sampled only while idle)
//   a_i      in  [width]   dividend, captured on the accepting edge
//   b_i      in  [width]   divisor, captured on the accepting edge
//   busy_o   out           division in progress
//   done_o   out           one-cycle completion pulse
//   q_o      out [width]   quotient, held until the next completion
//   r_o      out [width]   remainder, held until the next completion
//   div0_o   out           last completed division had a zero divisor

// full_sub_nbits -- ripple-borrow subtractor, s_o = a_i - b_i modulo 2**width.
//
// Ports
//   a_i  in  [width]  minuend
//   b_i  in  [width]  subtrahend
//   s_o  out [width]  difference
module full_sub_nbits #(
  parameter int width = 8
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] s_o
);

  logic borrow;

  // NOTE: every variable written here gets a value before any branch or loop
  // can skip it; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    s_o    = '0;
    borrow = 1'b0;
    for (int i = 0; i < width; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ borrow;
      borrow = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow);
    end
  end

endmodule

module seq_div_nbits #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [width-1:0] q_o,
  output logic [width-1:0] r_o,
  output logic             div0_o
);

  localparam int cnt_w = $clog2(width + 1);

  typedef enum logic {
    st_idle,
    st_run
  } state_t;

  state_t             state;
  logic [width-1:0]   a_reg;     // dividend, shifted out MSB first
  logic [width-1:0]   b_reg;     // divisor
  logic [width-1:0]   r_reg;     // partial remainder
  logic [width-1:0]   q_reg;     // quotient, shifted in LSB first
  logic [cnt_w-1:0]   cnt;       // steps already taken
  logic               div0_reg;

  logic [width:0]     p;         // remainder with the next dividend bit appended
  logic [width:0]     d;         // trial difference p - b
  logic               borrow;
  logic [width-1:0]   r_next;
  logic [width-1:0]   q_next;
  logic               last_step;

  assign p = {r_reg, a_reg[width-1]};

  full_sub_nbits #(
    .width(width + 1)
  ) u_sub (
    .a_i(p),
    .b_i({1'b0, b_reg}),
    .s_o(d)
  );

  // Because r_reg < b_reg always holds, p < 2*b_reg and a non-negative
  // difference fits in `width` bits, so the extra MSB is a clean borrow flag.
  // With b_reg == 0 the borrow never fires, giving all-ones quotient and the
  // dividend as remainder without a dedicated path.
  assign borrow    = d[width];
  assign r_next    = borrow ? p[width-1:0] : d[width-1:0];
  assign q_next    = {q_reg[width-2:0], ~borrow};
  assign last_step = (cnt == cnt_w'(width - 1));

  // NOTE: all state, including the datapath registers, is reset so an aborted
  // division leaves no stale operands and outputs come back to known zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= st_idle;
      a_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      q_reg    <= '0;
      cnt      <= '0;
      div0_reg <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      q_o      <= '0;
      r_o      <= '0;
      div0_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      done_o <= 1'b0;
      case (state)
        st_idle: begin
          if (start_i) begin
            a_reg    <= a_i;
            b_reg    <= b_i;
            r_reg    <= '0;
            q_reg    <= '0;
            cnt      <= '0;
            div0_reg <= (b_i == '0);
            busy_o   <= 1'b1;
            state    <= st_run;
          end
        end
        st_run: begin
          a_reg <= a_reg << 1;
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + cnt_w'(1);
          if (last_step) begin
            q_o    <= q_next;
            r_o    <= r_next;
            div0_o <= div0_reg;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_nbits.sv
// Testbench for seq_div_nbits (width = 8): table-driven divisions through a
// result scoreboard, hand-written handshake corner cases, and a random sweep.
module tb_seq_div_nbits;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div0;

  seq_div_nbits #(.width(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .a_i    (a_in),
    .b_i    (b_in),
    .busy_o (busy),
    .done_o (done),
    .q_o    (q),
    .r_o    (r),
    .div0_o (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one division, verify accept, latency, and the scoreboarded result.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ed, input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    e.q = eq; e.r = er; e.d = ed;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = W'($urandom);   // operand changes after accept must not matter
    b_in  = W'($urandom);
    check({tag, " busy after accept"}, 32'(busy), 1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, " latency"}, lat, W);
    e = sb.pop_front();
    if (seen) begin
      check({tag, " q"}, 32'(q), 32'(e.q));
      check({tag, " r"}, 32'(r), 32'(e.r));
      check({tag, " div0"}, 32'(div0), 32'(e.d));
      check({tag, " busy at done"}, 32'(busy), 0);
      @(posedge clk); #1;
      check({tag, " done pulse width"}, 32'(done), 0);
    end
  endtask

  vec_t vecs[11];

  initial begin
    int done_cnt;
    int done_at[$];
    logic [W-1:0] ra, rb;
    exp_t e;

    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2]  = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0};
    vecs[3]  = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0};
    vecs[4]  = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1};
    vecs[5]  = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
    vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[7]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[8]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[9]  = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0};
    vecs[10] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};

    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset q", 32'(q), 0);
    check("reset r", 32'(r), 0);
    check("reset div0", 32'(div0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven divisions.
    foreach (vecs[i])
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].d, $sformatf("vec%0d", i));

    // start pulse during a running division is ignored.
    @(negedge clk);
    start = 1'b1; a_in = 8'd100; b_in = 8'd7;
    @(posedge clk); #1;                       // edge k
    start = 1'b0;
    @(posedge clk); #1;                       // k+1
    @(posedge clk); #1;                       // k+2
    check("ignore held q", 32'(q), 255);      // previous result still held
    @(negedge clk);
    start = 1'b1; a_in = 8'd50; b_in = 8'd5;
    @(posedge clk); #1;                       // k+3
    start = 1'b0;
    done_cnt = 0;
    done_at.delete();
    for (int i = 4; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        done_at.push_back(i);
        check("ignore q", 32'(q), 14);
        check("ignore r", 32'(r), 2);
      end
    end
    check("ignore done count", done_cnt, 1);
    if (done_at.size() > 0) check("ignore done edge", done_at[0], 8);

    // start held high: back-to-back completions at k+8 and k+17.
    @(negedge clk);
    start = 1'b1; a_in = 8'd100; b_in = 8'd7;
    @(posedge clk); #1;                       // edge k
    done_at.delete();
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(i);
        check("b2b q", 32'(q), 14);
        check("b2b r", 32'(r), 2);
      end
    end
    start = 1'b0;
    check("b2b done count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      check("b2b first edge", done_at[0], 8);
      check("b2b second edge", done_at[1], 17);
    end
    @(posedge clk); #1;
    check("b2b done low", 32'(done), 0);
    check("b2b idle", 32'(busy), 0);

    // Reset in the middle of a division aborts it.
    run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "pre-reset");
    @(negedge clk);
    start = 1'b1; a_in = 8'd60; b_in = 8'd8;
    @(posedge clk); #1;                       // edge k
    start = 1'b0;
    repeat (4) @(posedge clk);                // edge k+4
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort q", 32'(q), 0);
    check("abort r", 32'(r), 0);
    check("abort div0", 32'(div0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    run_div(8'd60, 8'd8, 8'd7, 8'd4, 1'b0, "post-reset");

    // Random sweep against a division model and the a = q*b + r invariant.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 50 == 0) rb = '0;
      if (rb == '0) begin
        e.q = '1; e.r = ra; e.d = 1'b1;
      end else begin
        e.q = ra / rb; e.r = ra % rb; e.d = 1'b0;
      end
      run_div(ra, rb, e.q, e.r, e.d, "rand");
      if (rb != '0) begin
        check("rand invariant", 32'(q) * 32'(rb) + 32'(r), 32'(ra));
        check("rand r<b", 32'(r < rb), 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_div_nbits.md
# seq_div_nbits

Sequential unsigned restoring divider for the calculator datapath. It sits downstream of the operand registers and reuses `full_sub_nbits` as its per-step trial subtractor, so the calculator's divide key shares the subtractor path. A start/busy/done handshake lets the control FSM issue one division at a time. Results are held stable until the next completion.

## Interface
- `width`, default 8: operand, quotient and remainder width in bits; minimum 2.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request a division; sampled only while `busy_o` is 0.
- `a_i`  in  `width`  dividend (unsigned); sampled on the accepting edge.
- `b_i`  in  `width`  divisor (unsigned); sampled on the accepting edge.
- `busy_o`  out  1  division in progress.
- `done_o`  out  1  one-cycle pulse; `q_o`/`r_o`/`div0_o` are valid from this cycle.
- `q_o`  out  `width`  quotient, held until the next completion.
- `r_o`  out  `width`  remainder, held until the next completion.
- `div0_o`  out  1  the last completed division had `b_i` == 0; held with `q_o`.

## Operation
- States: IDLE and RUN.
- Internal registers:
  - dividend shift register A (`width`)
  - divisor B (`width`)
  - partial remainder R (`width`)
  - quotient shift register Q (`width`)
  - step counter (`$clog2(width+1)` bits)
  - div0 flag
- IDLE and `start_i`=1: load A=`a_i`, B=`b_i`, R=0, Q=0, counter=0, div0 flag=(`b_i`==0); go to RUN.
- IDLE and `start_i`=0: nothing changes.
- RUN, one step per edge:
  - P = {R, A[`width`-1]}, `width`+1 bits.
  - D = P − {1'b0, B}, computed by a `full_sub_nbits` instance with width `width`+1; the MSB of `s_o` is the borrow.
  - Borrow = 0: R = D[`width`-1:0], shift 1 into Q.
  - Borrow = 1: R = P[`width`-1:0], shift 0 into Q.
  - A shifts left by 1; the counter increments.
- On the step where the counter reaches `width`−1, the registers load:
  - `q_o` = final Q
  - `r_o` = final R
  - `div0_o` = div0 flag
  - `done_o` = 1
  - state returns to IDLE.
- Divide by zero needs no special path. The algorithm naturally yields `q_o` = all ones and `r_o` = `a_i`; `div0_o` = 1 flags the case.
- `start_i` while `busy_o` = 1 is ignored. It is not queued.
- `a_i`/`b_i` changes after the accepting edge have no effect.
- Result invariant when `b_i` != 0: `a_i` = `q_o`·`b_i` + `r_o`, with `r_o` < `b_i`.

## Timing
- Reset values (`rst_ni` = 0, asynchronous):
  - state IDLE
  - `busy_o` = 0, `done_o` = 0, `div0_o` = 0
  - `q_o` = 0, `r_o` = 0
  - all internal registers 0.
- Reset asserted mid-division aborts it: no `done_o` is produced and the outputs return to their reset values.
- Accepting edge k: `busy_o` = 1 from edge k.
- Edge k+`width`:
  - `busy_o` falls to 0.
  - `done_o` rises to 1.
  - `q_o`, `r_o` and `div0_o` update.
- Edge k+`width`+1: `done_o` returns to 0.
- Latency is fixed at `width` cycles from the accepting edge to `done_o`, independent of operand values.
- Back-to-back: `start_i` = 1 in the `done_o` cycle is accepted at edge k+`width`+1. Throughput is one division per `width`+1 cycles.
- `q_o`, `r_o` and `div0_o` change only on a completion edge or on reset.

## Test plan
- `width`=8, a=100, b=7, start pulse at edge k -> `busy_o`=1 over edges k..k+7; at edge k+8: `done_o`=1 for one cycle, `q_o`=14, `r_o`=2, `div0_o`=0.
- a=255, b=1 -> `q_o`=255, `r_o`=0. a=3, b=10 -> `q_o`=0, `r_o`=3. a=200, b=200 -> `q_o`=1, `r_o`=0.
- a=5, b=0 -> after 8 cycles: `q_o`=255, `r_o`=5, `div0_o`=1. The next division 9/3 -> `q_o`=3, `r_o`=0, `div0_o`=0.
- Start 100/7, then pulse `start_i` with a=50, b=5 at edge k+3 -> ignored; result is still 14 r 2 at edge k+8, and only one `done_o` pulse occurs.
- Hold `start_i`=1 continuously with 100/7 -> completions at edges k+8 and k+17, each giving 14 r 2; `done_o` is high exactly one cycle each time.
- Complete 100/7, then start 60/8 and drop `rst_ni` at k+4 -> all outputs 0 immediately and no `done_o`. After release, 60/8 -> `q_o`=7, `r_o`=4. A random sweep of 1000 operand pairs checks the invariant a = q·b + r.
